piped_queue_p: RTL and testbench
================================

# piped_queue_p

Parametrised successor to the 32-bit piped read queue: a synchronous FIFO whose output register (`dout`) sits between the storage RAM and the consumer, with zero-bubble bypass when the RAM is empty. It adds configurable width and depth, a true `full` flag with write back-pressure, an occupancy count, and a programmable almost-full threshold. It sits between producer units (ring/DMA receive paths) and the RISC core or other consumers that pop one word per cycle.

## Interface
- `WIDTH`, 32: data width in bits.
- `DEPTH_LOG2`, 6: log2 of RAM entries; total capacity = 2^DEPTH_LOG2 + 1 (RAM plus `dout`).
- `AF_THRESH`, 2^DEPTH_LOG2 - 4: `almost_full` asserts when count >= AF_THRESH.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `din` in WIDTH: write data.
- `wr_en` in 1: write request.
- `rd_en` in 1: read (pop) request; consumes the word currently on `dout`.
- `dout` out WIDTH: registered head-of-queue word; valid when `empty`=0.
- `empty` out 1: no valid word on `dout`.
- `full` out 1: count == 2^DEPTH_LOG2 + 1.
- `almost_full` out 1: count >= AF_THRESH.
- `count` out DEPTH_LOG2+2: words held (RAM + `dout`).
- `overflow`, `underflow` out 1: sticky error flags (only with `PIPED_QUEUE_ERRCHK_EN`).

## Operation
- Storage: WIDTH × 2^DEPTH_LOG2 dual-port RAM, asynchronous read at `ra`, synchronous write at `wa`.
- Pointers `ra`, `wa` are DEPTH_LOG2+1 bits (extra wrap bit); RAM address = low DEPTH_LOG2 bits. RQempty = (ra == wa); RQfull = (wa − ra == 2^DEPTH_LOG2). Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Internal `doutFull` register; `empty` = ~doutFull.
- Accepted write: wa_ok = wr_en & (~full | rd_en). Accepted read: rd_ok = rd_en & doutFull.
- With accepted signals, decisions are the same as in the 32-bit queue:
  - wa_ok only: if ~doutFull, load `dout` ← `din` and set doutFull; else write RAM, incWA.
  - rd_ok only: if ~RQempty, `dout` ← RAM[ra], incRA, doutFull stays 1; else clear doutFull.
  - Both: if RQempty, `dout` ← `din` (bypass); else `dout` ← RAM[ra], RAM[wa] ← `din`, incRA and incWA. doutFull unchanged.
  - Neither: no state change.
- Write and read together while `full`: accepted. Both pointers advance and the RAM stays full. The RAM read of the old word at the shared address precedes the write.
- Rejected write (`wr_en` & `full` & ~`rd_en`): ignored, no state change. Rejected read (`rd_en` & `empty`): ignored.
- `count` register: +1 on wa_ok & ~rd_ok, −1 on rd_ok & ~wa_ok, otherwise held. `full` and `almost_full` are decoded from the registered `count`.

## Timing
- Reset: `dout`=0, `empty`=1, `full`=0, `count`=0, `almost_full`=(AF_THRESH==0), `ra`=`wa`=0, `overflow`=`underflow`=0. Reset overrides any concurrent `wr_en`/`rd_en`. Reset mid-operation discards all contents.
- Write-to-read latency: 1 cycle. A word written into an empty queue at edge N appears on `dout` with `empty`=0 after edge N.
- Pop: after the edge where `rd_en`=1, `dout` shows the next word, or `empty`=1. No bubble on back-to-back reads.
- Flags update on the same edge as the causing transfer. There is no combinational path from `wr_en`/`rd_en` to any output.

## Configuration
- `PIPED_QUEUE_ERRCHK_EN` defined: the `overflow` and `underflow` ports exist.
  - `overflow` sets on a rejected write; `underflow` sets on a rejected read.
  - Both flags are sticky and cleared only by `rst`.
- Undefined: the ports and their logic are absent. Rejected operations are still silently ignored.

## Test plan
- Reset, then write 0xA5A5_0001 once -> next cycle `empty`=0, `dout`=0xA5A5_0001, `count`=1; RAM pointers unchanged.
- DEPTH_LOG2=2, write 1..5 without reading -> `full`=1 and `count`=5 after the 5th write. Write 6 -> ignored; `overflow`=1 with ERRCHK. Then read 5 times -> `dout` sequence 1,2,3,4,5, then `empty`=1.
- Continuous simultaneous write/read at count=1 for 20 cycles with incrementing data -> `count` stays 1 and `dout` lags `din` by one cycle (bypass path; RAM pointers unchanged).
- At `full` (count=5, DEPTH_LOG2=2), assert `wr_en`+`rd_en` for 10 cycles -> stays full, data order preserved, pointers wrap past the 3-bit boundary correctly.
- Read on empty queue -> no state change; `underflow`=1 with ERRCHK, stays 1 until `rst`.
- AF_THRESH=3, DEPTH_LOG2=2: `almost_full` rises on the edge `count` goes 2→3 and falls on 3→2. Asserting `rst` with count=4 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/piped_queue_p_if.sv
// piped_queue_p_if: producer/consumer handshake bundle for piped_queue_p.
// The sticky error flags exist only when PIPED_QUEUE_ERRCHK_EN is defined.
interface piped_queue_p_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6
);
  logic [WIDTH-1:0]      din;
  logic                  wr_en;
  logic                  rd_en;
  logic [WIDTH-1:0]      dout;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_LOG2+1:0] count;
`ifdef PIPED_QUEUE_ERRCHK_EN
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, empty, full, almost_full, count, overflow, underflow
  );
  modport slave (
    input  din, wr_en, rd_en,
    output dout, empty, full, almost_full, count, overflow, underflow
  );
`else
  modport master (
    output din, wr_en, rd_en,
    input  dout, empty, full, almost_full, count
  );
  modport slave (
    input  din, wr_en, rd_en,
    output dout, empty, full, almost_full, count
  );
`endif
endinterface

// File: rtl/piped_queue_p.sv
// piped_queue_p: synchronous FIFO with a registered head word (dout) in front
// of a 2^DEPTH_LOG2-entry RAM, zero-bubble bypass when the RAM is empty,
// full/almost_full flags and an occupancy count. Total capacity is
// 2^DEPTH_LOG2 + 1 words.
// Optional feature macro: PIPED_QUEUE_ERRCHK_EN adds sticky overflow/underflow.
module piped_queue_p #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int AF_THRESH  = 2**DEPTH_LOG2 - 4
) (
  input logic             clk,
  input logic             rst,
  piped_queue_p_if.slave  q
);
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int CNT_W = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(2**DEPTH_LOG2 + 1);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);

  logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_full;
  logic [PTR_W-1:0] r_ra;
  logic [PTR_W-1:0] r_wa;
  logic [CNT_W-1:0] r_count;

  logic             w_full;
  logic             w_rq_empty;
  logic             w_wa_ok;
  logic             w_rd_ok;
  logic             w_ram_we;
  logic [WIDTH-1:0] w_ram_rd;

  assign w_full     = (r_count == FULL_C);
  assign w_rq_empty = (r_ra == r_wa);
  // A pop frees a slot in the same cycle, so a write alongside a read is
  // accepted even when full.
  assign w_wa_ok    = q.wr_en & (~w_full | q.rd_en);
  assign w_rd_ok    = q.rd_en & r_dout_full;
  // The RAM takes the word whenever dout is occupied and it is not bypassed.
  assign w_ram_we   = w_wa_ok & r_dout_full & (~w_rd_ok | ~w_rq_empty);
  assign w_ram_rd   = r_mem[r_ra[DEPTH_LOG2-1:0]];

  // RAM write port.
  // NOTE: storage is not reset; pointers and dout_full define what is valid,
  // and leaving the array reset-free lets it map onto real RAM.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[r_wa[DEPTH_LOG2-1:0]] <= q.din;
  end

  // Head register, pointers and occupancy.
  // NOTE: non-blocking assignments make the async RAM read see the old word
  // even when the write lands on the same address in this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout      <= '0;
      r_dout_full <= 1'b0;
      r_ra        <= '0;
      r_wa        <= '0;
      r_count     <= '0;
    end else begin
      unique case ({w_wa_ok, w_rd_ok})
        2'b10: begin
          if (!r_dout_full) begin
            r_dout      <= q.din;
            r_dout_full <= 1'b1;
          end else begin
            r_wa <= r_wa + PTR_W'(1);
          end
        end
        2'b01: begin
          if (!w_rq_empty) begin
            r_dout <= w_ram_rd;
            r_ra   <= r_ra + PTR_W'(1);
          end else begin
            r_dout_full <= 1'b0;
          end
        end
        2'b11: begin
          if (w_rq_empty) begin
            r_dout <= q.din;
          end else begin
            r_dout <= w_ram_rd;
            r_ra   <= r_ra + PTR_W'(1);
            r_wa   <= r_wa + PTR_W'(1);
          end
        end
        default: ;
      endcase

      if (w_wa_ok && !w_rd_ok)      r_count <= r_count + CNT_W'(1);
      else if (w_rd_ok && !w_wa_ok) r_count <= r_count - CNT_W'(1);
    end
  end

  assign q.dout        = r_dout;
  assign q.empty       = ~r_dout_full;
  assign q.full        = w_full;
  assign q.almost_full = (r_count >= AF_C);
  assign q.count       = r_count;

`ifdef PIPED_QUEUE_ERRCHK_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags for rejected write / rejected read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (q.wr_en && w_full && !q.rd_en) r_overflow  <= 1'b1;
      if (q.rd_en && !r_dout_full)       r_underflow <= 1'b1;
    end
  end

  assign q.overflow  = r_overflow;
  assign q.underflow = r_underflow;
`endif
endmodule

// File: tb/tb_piped_queue_p.sv
// tb_piped_queue_p: scoreboard bench for piped_queue_p with DEPTH_LOG2=2
// (capacity 5) and AF_THRESH=3.
module tb_piped_queue_p;
  localparam int WIDTH = 32;
  localparam int DL2   = 2;
  localparam int AFT   = 3;
  localparam int CAP   = 2**DL2 + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [WIDTH-1:0] sb[$];
`ifdef PIPED_QUEUE_ERRCHK_EN
  logic exp_ovf = 1'b0;
  logic exp_udf = 1'b0;
`endif

  piped_queue_p_if #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) qif ();
  piped_queue_p #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2), .AF_THRESH(AFT)) dut (
    .clk(clk),
    .rst(rst),
    .q  (qif)
  );

  always #5 clk = ~clk;

  // One clock with the given request; the scoreboard is updated from the
  // externally visible acceptance rules. Returns #1 after the edge.
  task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bit wa_ok, rd_ok;
    qif.din   = d;
    qif.wr_en = wr;
    qif.rd_en = rd;
    rd_ok = rd && (sb.size() > 0);
    wa_ok = wr && ((sb.size() < CAP) || rd);
`ifdef PIPED_QUEUE_ERRCHK_EN
    if (wr && !wa_ok) exp_ovf = 1'b1;
    if (rd && !rd_ok) exp_udf = 1'b1;
`endif
    if (rd_ok) void'(sb.pop_front());
    if (wa_ok) sb.push_back(d);
    @(posedge clk);
    #1;
    qif.wr_en = 1'b0;
    qif.rd_en = 1'b0;
  endtask

  // Reset with both requests asserted to show reset dominates.
  task automatic apply_reset();
    rst       = 1'b1;
    qif.wr_en = 1'b1;
    qif.rd_en = 1'b1;
    qif.din   = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    qif.wr_en = 1'b0;
    qif.rd_en = 1'b0;
    sb.delete();
`ifdef PIPED_QUEUE_ERRCHK_EN
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (qif.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", qif.empty); end
    total++; if (qif.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", qif.count); end
    total++; if (qif.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", qif.full); end
    total++; if (qif.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%b exp=0", qif.almost_full); end
    total++; if (qif.dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=0", qif.dout); end
`ifdef PIPED_QUEUE_ERRCHK_EN
    total++; if ({qif.overflow, qif.underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {qif.overflow, qif.underflow}); end
`endif
  endtask

  task automatic test_single_write();
    drive(1'b1, 1'b0, 32'hA5A5_0001);
    total++; if (qif.empty !== 1'b0) begin bad++; $display("FAIL sw_empty got=%b exp=0", qif.empty); end
    total++; if (qif.dout !== 32'hA5A5_0001) begin bad++; $display("FAIL sw_dout got=%h exp=a5a50001", qif.dout); end
    total++; if (qif.count !== 4'd1) begin bad++; $display("FAIL sw_count got=%0d exp=1", qif.count); end
    drive(1'b0, 1'b1, '0);
    total++; if (qif.empty !== 1'b1) begin bad++; $display("FAIL sw_pop_empty got=%b exp=1", qif.empty); end
  endtask

  task automatic test_fill_drain();
    logic [WIDTH-1:0] exp_w;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b0, WIDTH'(i));
      total++; if (qif.count !== 4'(i)) begin bad++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, qif.count, i); end
      total++; if (qif.full !== (i == 5)) begin bad++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, qif.full, (i == 5)); end
      total++; if (qif.dout !== 32'd1) begin bad++; $display("FAIL fill_head i=%0d got=%h exp=1", i, qif.dout); end
    end
    drive(1'b1, 1'b0, 32'd6);
    total++; if (qif.count !== 4'd5 || qif.full !== 1'b1) begin bad++; $display("FAIL reject_wr count=%0d full=%b exp=5/1", qif.count, qif.full); end
`ifdef PIPED_QUEUE_ERRCHK_EN
    total++; if (qif.overflow !== 1'b1) begin bad++; $display("FAIL overflow got=%b exp=1", qif.overflow); end
`endif
    for (int i = 1; i <= 5; i++) begin
      exp_w = sb.size() > 0 ? sb[0] : 'x;
      total++; if (qif.empty !== 1'b0 || qif.dout !== exp_w) begin bad++; $display("FAIL drain_dout i=%0d got=%h exp=%h", i, qif.dout, exp_w); end
      total++; if (exp_w !== WIDTH'(i)) begin bad++; $display("FAIL drain_order i=%0d got=%h exp=%0d", i, exp_w, i); end
      drive(1'b0, 1'b1, '0);
    end
    total++; if (qif.empty !== 1'b1 || qif.count !== 4'd0) begin bad++; $display("FAIL drain_end empty=%b count=%0d exp=1/0", qif.empty, qif.count); end
`ifdef PIPED_QUEUE_ERRCHK_EN
    total++; if (qif.overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%b exp=1", qif.overflow); end
`endif
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] prev;
    apply_reset();
    drive(1'b1, 1'b0, 32'h1000);
    prev = 32'h1000;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b1, 32'h1000 + WIDTH'(i));
      total++; if (qif.count !== 4'd1) begin bad++; $display("FAIL bypass_count i=%0d got=%0d exp=1", i, qif.count); end
      total++; if (qif.dout !== prev + 1) begin bad++; $display("FAIL bypass_dout i=%0d got=%h exp=%h", i, qif.dout, prev + 1); end
      prev = prev + 1;
    end
  endtask

  task automatic test_full_rw();
    apply_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 32'h2000 + WIDTH'(i));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'h3000 + WIDTH'(i));
      total++; if (qif.full !== 1'b1 || qif.count !== 4'd5) begin bad++; $display("FAIL frw_full i=%0d full=%b count=%0d exp=1/5", i, qif.full, qif.count); end
      // Word i+1 of the 15-word stream 2000..2004,3000..3009 is now the head.
      total++; if (qif.dout !== (i < 4 ? 32'h2001 + WIDTH'(i) : 32'h3000 + WIDTH'(i - 4))) begin
        bad++; $display("FAIL frw_order i=%0d got=%h", i, qif.dout);
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (qif.dout !== 32'h3005 + WIDTH'(i)) begin bad++; $display("FAIL frw_drain i=%0d got=%h exp=%h", i, qif.dout, 32'h3005 + WIDTH'(i)); end
      drive(1'b0, 1'b1, '0);
    end
    total++; if (qif.empty !== 1'b1) begin bad++; $display("FAIL frw_end_empty got=%b exp=1", qif.empty); end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(1'b0, 1'b1, '0);
    total++; if (qif.empty !== 1'b1 || qif.count !== 4'd0 || qif.dout !== 32'h0) begin
      bad++; $display("FAIL udf_state empty=%b count=%0d dout=%h exp=1/0/0", qif.empty, qif.count, qif.dout);
    end
`ifdef PIPED_QUEUE_ERRCHK_EN
    total++; if (qif.underflow !== 1'b1) begin bad++; $display("FAIL underflow got=%b exp=1", qif.underflow); end
    drive(1'b1, 1'b0, 32'h55);
    drive(1'b0, 1'b1, '0);
    total++; if (qif.underflow !== exp_udf) begin bad++; $display("FAIL underflow_sticky got=%b exp=%b", qif.underflow, exp_udf); end
    apply_reset();
    total++; if (qif.underflow !== 1'b0) begin bad++; $display("FAIL underflow_clr got=%b exp=0", qif.underflow); end
`endif
  endtask

  task automatic test_almost_full();
    logic exp_af[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic wr_seq[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    apply_reset();
    // count goes 1,2,3,4,3,2
    for (int i = 0; i < 6; i++) begin
      drive(wr_seq[i], !wr_seq[i], 32'h40 + WIDTH'(i));
      total++; if (qif.almost_full !== exp_af[i] || qif.count !== 4'(sb.size())) begin
        bad++; $display("FAIL af step=%0d af=%b exp=%b count=%0d exp=%0d", i, qif.almost_full, exp_af[i], qif.count, sb.size());
      end
    end
    drive(1'b1, 1'b0, 32'h50);
    drive(1'b1, 1'b0, 32'h51);
    total++; if (qif.count !== 4'd4) begin bad++; $display("FAIL af_pre_rst count=%0d exp=4", qif.count); end
    apply_reset();
    total++; if (qif.empty !== 1'b1 || qif.count !== 4'd0 || qif.full !== 1'b0 || qif.almost_full !== 1'b0 || qif.dout !== 32'h0) begin
      bad++; $display("FAIL mid_rst empty=%b count=%0d full=%b af=%b dout=%h", qif.empty, qif.count, qif.full, qif.almost_full, qif.dout);
    end
  endtask

  task automatic test_random();
    logic wr, rd;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      drive(wr, rd, $urandom);
      total++; if (qif.count !== 4'(sb.size()) || qif.empty !== (sb.size() == 0) || qif.full !== (sb.size() == CAP)) begin
        bad++; $display("FAIL rnd_flags i=%0d count=%0d exp=%0d empty=%b full=%b", i, qif.count, sb.size(), qif.empty, qif.full);
      end
      if (sb.size() > 0) begin
        total++; if (qif.dout !== sb[0]) begin bad++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, qif.dout, sb[0]); end
      end
`ifdef PIPED_QUEUE_ERRCHK_EN
      total++; if ({qif.overflow, qif.underflow} !== {exp_ovf, exp_udf}) begin
        bad++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, {qif.overflow, qif.underflow}, {exp_ovf, exp_udf});
      end
`endif
    end
  endtask

  initial begin
    qif.din   = '0;
    qif.wr_en = 1'b0;
    qif.rd_en = 1'b0;
    test_reset();
    test_single_write();
    test_fill_drain();
    test_bypass();
    test_full_rw();
    test_underflow();
    test_almost_full();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
